gemv_operand_loader: RTL and testbench
======================================

Name: gemv_operand_loader

Overview:
- Byte-stream front end for the tiled GEMV engine.
- Accepts one operand frame over a valid/ready byte interface: x vector, then bias vector, then the weight matrix in row-major order.
- Writes the frame into register storage and presents it as the parallel w/x/bias arrays the GEMV consumes.
- Holds the operands stable, with load_done high, until the consumer acknowledges; then accepts the next frame.

Parameters:
- DATA_WIDTH, 8, element width; one stream beat carries one element.
- ROWS, 128, output rows; length of bias and first dimension of w.
- COLUMNS, 128, input columns; length of x and second dimension of w.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_WIDTH  stream element, interpreted as signed.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a beat this cycle.
- in_last  in  1  marks the final beat of a frame.
- x_out  out  signed DATA_WIDTH x [0:COLUMNS-1]  x storage.
- bias_out  out  signed DATA_WIDTH x [0:ROWS-1]  bias storage.
- w_out  out  signed DATA_WIDTH x [0:ROWS-1][0:COLUMNS-1]  weight storage.
- load_done  out  1  level signal: a complete, well-formed frame is held.
- consumed  in  1  single-cycle pulse: consumer has finished with the operands.
- err_len  out  1  sticky flag: the last frame had the wrong length.

Behaviour:
- Beat accepted iff in_valid && in_ready at a rising clk edge.
- Frame length: L = COLUMNS + ROWS + ROWS*COLUMNS beats.
- Counter elem_cnt is sized for max(COLUMNS, ROWS*COLUMNS). It resets to 0 on every phase change.
- States:
  - LOAD_X: in_ready=1. Beat k writes x_out[k]. After beat COLUMNS-1 -> LOAD_B.
  - LOAD_B: in_ready=1. Beat k writes bias_out[k]. After beat ROWS-1 -> LOAD_W.
  - LOAD_W: in_ready=1. Beat k writes w_out[k / COLUMNS][k % COLUMNS].
    - Final beat (k = ROWS*COLUMNS-1) with in_last=1 -> FULL.
    - Final beat with in_last=0 -> DRAIN, and err_len set.
  - FULL: in_ready=0, load_done=1. consumed=1 -> LOAD_X. load_done falls on that same edge. Storage keeps its contents until overwritten.
  - DRAIN: in_ready=1. Accepted beats are discarded and storage is not written. A beat with in_last=1 -> LOAD_X.
- Early in_last: a beat with in_last=1 accepted in LOAD_X, LOAD_B or LOAD_W before the final weight beat is handled as follows:
  - That beat is still written to storage.
  - err_len is set and the state goes to LOAD_X.
  - Storage is left partially overwritten, and load_done stays 0.
- err_len clearing: cleared on the first beat accepted in LOAD_X with elem_cnt=0. If that beat is itself an early in_last, err_len is set again on the same edge; set has priority over clear.
- load_done latency: the final beat is accepted at edge N, and load_done is high from edge N. It is registered, so it is visible in the cycle after the beat. There is no combinational path from in_valid to load_done.
- consumed is ignored in every state except FULL, including the cycle in which the final beat is accepted.
- in_ready depends only on the state register (registered decode), with no combinational dependence on in_valid or consumed.
- Stalls: in_valid may drop at any time. Counters and state hold while no beat is accepted.
- Reset (asynchronous):
  - Outputs: all x_out, bias_out and w_out elements = 0; load_done=0; err_len=0.
  - Internal: state=LOAD_X, elem_cnt=0.
  - in_ready is 0 while rst is high and 1 from the first cycle after release.
- Reset mid-frame discards the partial frame. The next accepted beat is x[0].
- No arithmetic is performed. Elements pass through bit-exactly.

Test Plan:
All scenarios use ROWS=4, COLUMNS=8, so L = 8 + 4 + 32 = 44.
- Nominal frame: stream bytes 0x00..0x2B continuously, with in_last on beat 43.
  - Expect x_out[k]=k and bias_out[k]=8+k.
  - Expect w_out[r][c]=12+8r+c, so w_out[3][7]=0x2B.
  - load_done rises in the cycle after beat 43, and in_ready=0.
- Backpressure hold: in FULL, drive in_valid=1 for 10 cycles with no consumed.
  - Expect in_ready=0 throughout and no storage change.
  - Pulse consumed: load_done falls next cycle and in_ready=1.
- Bubbles: repeat the nominal frame with in_valid toggling randomly at about 50%.
  - Expect identical storage contents.
  - load_done rises exactly one cycle after the 44th accepted beat.
- Short frame: in_last on beat 20, which is a weight element.
  - Expect err_len=1, load_done=0, next state LOAD_X.
  - Then send a correct 44-beat frame: err_len clears on its first beat, and load_done=1 at the end.
- Long frame: 44 beats with no in_last, then 3 more beats, the third with in_last.
  - Expect err_len=1 and load_done never asserted.
  - The extra beats do not modify storage; the next frame loads correctly.
- Reset mid-frame: assert rst after 30 beats.
  - Expect all storage=0, load_done=0, in_ready=0 during reset.
  - A following nominal frame loads correctly.

Source files
------------

// File: rtl/gemv_operand_loader.sv
// ============================================================================
// Module   : gemv_operand_loader
// Purpose  : Byte-stream front end that assembles x, bias and w operand frames
//            for the tiled GEMV engine and holds them until consumed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gemv_operand_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 128,
    parameter int COLUMNS    = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    output logic signed [DATA_WIDTH-1:0] x_out    [0:COLUMNS-1],
    output logic signed [DATA_WIDTH-1:0] bias_out [0:ROWS-1],
    output logic signed [DATA_WIDTH-1:0] w_out    [0:ROWS-1][0:COLUMNS-1],
    output logic                         load_done,
    input  logic                         consumed,
    output logic                         err_len
);

    localparam int CNT_W = (ROWS * COLUMNS > 1) ? $clog2(ROWS * COLUMNS) : 1;

    localparam logic [CNT_W-1:0] c_x_last = CNT_W'(COLUMNS - 1);
    localparam logic [CNT_W-1:0] c_b_last = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] c_w_last = CNT_W'(ROWS * COLUMNS - 1);

    typedef enum logic [2:0] {
        S_LOAD_X = 3'd0,
        S_LOAD_B = 3'd1,
        S_LOAD_W = 3'd2,
        S_FULL   = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_elem_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_alive;
    logic             r_err_len;
    logic             w_err_set;
    logic             w_err_clr;
    logic             w_accept;
    logic             w_wr_x;
    logic             w_wr_b;
    logic             w_wr_w;

    // r_alive keeps in_ready low while rst is asserted and releases it one edge later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_LOAD_X;
            r_elem_cnt <= '0;
            r_alive    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_elem_cnt <= w_cnt_nxt;
            r_alive    <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_elem_cnt;
        w_err_set   = 1'b0;
        case (r_state)
            S_LOAD_X, S_LOAD_B: begin
                if (w_accept) begin
                    if (in_last) begin
                        w_state_nxt = S_LOAD_X;
                        w_cnt_nxt   = '0;
                        w_err_set   = 1'b1;
                    end else if (r_elem_cnt == ((r_state == S_LOAD_X) ? c_x_last : c_b_last)) begin
                        w_state_nxt = (r_state == S_LOAD_X) ? S_LOAD_B : S_LOAD_W;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_elem_cnt + CNT_W'(1);
                    end
                end
            end
            S_LOAD_W: begin
                if (w_accept) begin
                    w_cnt_nxt = '0;
                    if (r_elem_cnt == c_w_last) begin
                        w_state_nxt = in_last ? S_FULL : S_DRAIN;
                        w_err_set   = !in_last;
                    end else if (in_last) begin
                        w_state_nxt = S_LOAD_X;
                        w_err_set   = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_elem_cnt + CNT_W'(1);
                    end
                end
            end
            S_FULL: begin
                if (consumed) begin
                    w_state_nxt = S_LOAD_X;
                end
            end
            S_DRAIN: begin
                if (w_accept && in_last) begin
                    w_state_nxt = S_LOAD_X;
                end
            end
            default: begin
                w_state_nxt = S_LOAD_X;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign in_ready  = r_alive && (r_state != S_FULL);
    assign w_accept  = in_valid && in_ready;
    assign load_done = (r_state == S_FULL);
    assign err_len   = r_err_len;

    assign w_wr_x    = w_accept && (r_state == S_LOAD_X);
    assign w_wr_b    = w_accept && (r_state == S_LOAD_B);
    assign w_wr_w    = w_accept && (r_state == S_LOAD_W);
    assign w_err_clr = w_wr_x && (r_elem_cnt == '0);

    // Set wins over clear so an early in_last on a frame's first beat stays flagged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_len <= 1'b0;
        end else if (w_err_set) begin
            r_err_len <= 1'b1;
        end else if (w_err_clr) begin
            r_err_len <= 1'b0;
        end
    end

    for (genvar k = 0; k < COLUMNS; k++) begin : g_x
        localparam logic [CNT_W-1:0] c_idx = CNT_W'(k);
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                x_out[k] <= '0;
            end else if (w_wr_x && (r_elem_cnt == c_idx)) begin
                x_out[k] <= in_data;
            end
        end
    end

    for (genvar k = 0; k < ROWS; k++) begin : g_bias
        localparam logic [CNT_W-1:0] c_idx = CNT_W'(k);
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                bias_out[k] <= '0;
            end else if (w_wr_b && (r_elem_cnt == c_idx)) begin
                bias_out[k] <= in_data;
            end
        end
    end

    // Row-major weight addressing: element index r*COLUMNS+c decoded per cell
    for (genvar r = 0; r < ROWS; r++) begin : g_w_row
        for (genvar c = 0; c < COLUMNS; c++) begin : g_w_col
            localparam logic [CNT_W-1:0] c_idx = CNT_W'(r * COLUMNS + c);
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    w_out[r][c] <= '0;
                end else if (w_wr_w && (r_elem_cnt == c_idx)) begin
                    w_out[r][c] <= in_data;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gemv_operand_loader.sv
// ============================================================================
// Module   : tb_gemv_operand_loader
// Purpose  : Directed self-checking bench for gemv_operand_loader (4x8 tile).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gemv_operand_loader;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int C  = 8;
    localparam int L  = C + R + R * C;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic signed [DW-1:0] x_out    [0:C-1];
    logic signed [DW-1:0] bias_out [0:R-1];
    logic signed [DW-1:0] w_out    [0:R-1][0:C-1];
    logic                 load_done;
    logic                 consumed;
    logic                 err_len;

    int checks = 0;
    int errors = 0;

    gemv_operand_loader #(.DATA_WIDTH(DW), .ROWS(R), .COLUMNS(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .x_out    (x_out),
        .bias_out (bias_out),
        .w_out    (w_out),
        .load_done(load_done),
        .consumed (consumed),
        .err_len  (err_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat from a falling edge and hold it until accepted.
    task automatic send(input logic [7:0] d, input logic l, input logic bubbles);
        int guard = 0;
        if (bubbles) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        @(negedge clk);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            errors++;
            $error("FAIL ready_timeout: observed in_ready=0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends beats 0..n-1 of value base+i, in_last on index last_at (-1: none).
    task automatic send_beats(input logic [7:0] base, input int n, input int last_at,
                              input logic bubbles);
        for (int i = 0; i < n; i++) begin
            send(base + 8'(i), (i == last_at), bubbles);
        end
    endtask

    task automatic check_storage(input string tag, input logic [7:0] base, input logic zero);
        for (int k = 0; k < C; k++)
            check({tag, "_x"}, x_out[k], zero ? 8'h00 : base + 8'(k));
        for (int k = 0; k < R; k++)
            check({tag, "_bias"}, bias_out[k], zero ? 8'h00 : base + 8'(C + k));
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                check({tag, "_w"}, w_out[r][c], zero ? 8'h00 : base + 8'(C + R + r * C + c));
    endtask

    task automatic consume();
        @(negedge clk);
        consumed = 1'b1;
        @(posedge clk);
        #1;
        consumed = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        consumed = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", in_ready, 1'b0);
        check("rst_done", load_done, 1'b0);
        check("rst_err", err_len, 1'b0);
        check_storage("rst", 8'h00, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1'b1);

        // Nominal frame 0x00..0x2B
        send_beats(8'h00, L - 1, -1, 1'b0);
        check("nom_done_before_last", load_done, 1'b0);
        send(8'h2B, 1'b1, 1'b0);
        check("nom_done", load_done, 1'b1);
        check("nom_ready_full", in_ready, 1'b0);
        check("nom_err", err_len, 1'b0);
        check("nom_w37", w_out[3][7], 8'h2B);
        check_storage("nom", 8'h00, 1'b0);

        // Backpressure hold in FULL
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'hFF;
            check("hold_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("hold_done", load_done, 1'b1);
        check_storage("hold", 8'h00, 1'b0);
        consume();
        check("cons_done", load_done, 1'b0);
        check("cons_ready", in_ready, 1'b1);

        // Bubbled frame with distinct values
        send_beats(8'h40, L - 1, -1, 1'b1);
        check("bub_done_before_last", load_done, 1'b0);
        send(8'h40 + 8'(L - 1), 1'b1, 1'b1);
        check("bub_done", load_done, 1'b1);
        check_storage("bub", 8'h40, 1'b0);
        consume();

        // Short frame: in_last on beat 20 (weight w[1][0])
        send_beats(8'h80, 21, 20, 1'b0);
        check("short_err", err_len, 1'b1);
        check("short_done", load_done, 1'b0);
        check("short_ready", in_ready, 1'b1);
        check("short_w10", w_out[1][0], 8'h94);
        check("short_w11_old", w_out[1][1], 8'h40 + 8'd21);
        send(8'h10, 1'b0, 1'b0);
        check("short_err_clr", err_len, 1'b0);
        check("short_x0_next", x_out[0], 8'h10);
        send_beats(8'h11, L - 1, L - 2, 1'b0);
        check("short_recover_done", load_done, 1'b1);
        check("short_recover_err", err_len, 1'b0);
        check_storage("short_recover", 8'h10, 1'b0);
        consume();

        // Long frame: 44 beats without in_last, then 3 drained beats
        send_beats(8'h20, L, -1, 1'b0);
        check("long_done", load_done, 1'b0);
        check("long_err", err_len, 1'b1);
        check("long_ready", in_ready, 1'b1);
        check_storage("long", 8'h20, 1'b0);
        send_beats(8'hEE, 3, 2, 1'b0);
        check("drain_done", load_done, 1'b0);
        check("drain_err", err_len, 1'b1);
        check_storage("drain", 8'h20, 1'b0);
        send_beats(8'h30, L, L - 1, 1'b0);
        check("long_recover_done", load_done, 1'b1);
        check("long_recover_err", err_len, 1'b0);
        check_storage("long_recover", 8'h30, 1'b0);
        consume();

        // Reset after 30 beats of a frame
        send_beats(8'h50, 30, -1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", in_ready, 1'b0);
        check("mid_rst_done", load_done, 1'b0);
        check_storage("mid_rst", 8'h00, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        send_beats(8'h00, L, L - 1, 1'b0);
        check("after_rst_done", load_done, 1'b1);
        check("after_rst_err", err_len, 1'b0);
        check_storage("after_rst", 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
